// File: rtl/gf_chien_search.sv
// Sequential Chien search over GF(2^8): evaluates the error-locator polynomial
// at alpha^j for j = 0..m-1, one point per clock, streaming out the error
// positions of every root and finishing with a root count and failure flag.
module gf_chien_search #(
  parameter int m    = 255,
  parameter int SIZE = $clog2(m),
  parameter int T    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [(T+1)*SIZE-1:0] flat_lambda,
  output logic                  busy,
  output logic                  pos_valid,
  output logic [SIZE-1:0]       pos,
  output logic                  done,
  output logic [SIZE-1:0]       err_count,
  output logic                  fail
);

  localparam int DW = $clog2(T + 1);
  localparam logic [SIZE-1:0] PolyLow = SIZE'(32'h11D);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  // Shift-and-add multiply, reducing by the primitive polynomial on overflow.
  function automatic logic [SIZE-1:0] gf_mul(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
    logic [SIZE-1:0] acc;
    logic [SIZE-1:0] aa;
    acc = '0;
    aa  = a;
    for (int i = 0; i < SIZE; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = aa[SIZE-1] ? ((aa << 1) ^ PolyLow) : (aa << 1);
    end
    return acc;
  endfunction

  // alpha^k; only ever called with loop constants, so it folds to a constant.
  function automatic logic [SIZE-1:0] gf_pow(input int k);
    logic [SIZE-1:0] r;
    r = SIZE'(1);
    for (int i = 0; i < k; i++) r = gf_mul(r, SIZE'(2));
    return r;
  endfunction

  state_t          state_q, state_d;
  logic [SIZE-1:0] term_q [T+1];
  logic [SIZE-1:0] term_d [T+1];
  logic [DW-1:0]   deg_q, deg_d;
  logic [SIZE-1:0] j_q, j_d;
  logic [SIZE-1:0] errCount_q, errCount_d;
  logic            fail_q, fail_d;
  logic            busy_q, busy_d;
  logic            posValid_q, posValid_d;
  logic [SIZE-1:0] pos_q, pos_d;
  logic            done_q, done_d;

  logic [SIZE-1:0] sum;
  logic            sumZero;
  logic [SIZE-1:0] countNext;
  logic [DW-1:0]   newDeg;

  // Current evaluation Lambda(alpha^j) is simply the XOR of all running terms.
  always_comb begin
    sum = '0;
    for (int k = 0; k <= T; k++) sum = sum ^ term_q[k];
  end

  assign sumZero   = (sum == '0);
  assign countNext = errCount_q + {{(SIZE-1){1'b0}}, sumZero};

  // Degree of the incoming polynomial: index of the highest nonzero coefficient.
  always_comb begin
    newDeg = '0;
    for (int k = 0; k <= T; k++) begin
      if (flat_lambda[k*SIZE +: SIZE] != '0) newDeg = DW'(k);
    end
  end

  // Next-state logic for the IDLE -> SEARCH -> DONE sequence and its datapath.
  always_comb begin
    state_d    = state_q;
    term_d     = term_q;
    deg_d      = deg_q;
    j_d        = j_q;
    errCount_d = errCount_q;
    fail_d     = fail_q;
    busy_d     = busy_q;
    posValid_d = 1'b0;
    pos_d      = pos_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          for (int k = 0; k <= T; k++) term_d[k] = flat_lambda[k*SIZE +: SIZE];
          deg_d      = newDeg;
          j_d        = '0;
          errCount_d = '0;
          fail_d     = 1'b0;
          busy_d     = 1'b1;
          state_d    = SEARCH;
        end
      end
      SEARCH: begin
        if (sumZero) begin
          posValid_d = 1'b1;
          pos_d      = (j_q == '0) ? '0 : SIZE'(m) - j_q;
          errCount_d = countNext;
        end
        for (int k = 0; k <= T; k++) term_d[k] = gf_mul(term_q[k], gf_pow(k));
        j_d = j_q + SIZE'(1);
        if (j_q == SIZE'(m - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          // term[0] is multiplied by alpha^0 every cycle, so it still holds lambda0.
          fail_d  = (term_q[0] == '0) || (countNext != SIZE'(deg_q));
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset also aborts a search in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      for (int k = 0; k <= T; k++) term_q[k] <= '0;
      deg_q      <= '0;
      j_q        <= '0;
      errCount_q <= '0;
      fail_q     <= 1'b0;
      busy_q     <= 1'b0;
      posValid_q <= 1'b0;
      pos_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      term_q     <= term_d;
      deg_q      <= deg_d;
      j_q        <= j_d;
      errCount_q <= errCount_d;
      fail_q     <= fail_d;
      busy_q     <= busy_d;
      posValid_q <= posValid_d;
      pos_q      <= pos_d;
      done_q     <= done_d;
    end
  end

  assign busy      = busy_q;
  assign pos_valid = posValid_q;
  assign pos       = pos_q;
  assign done      = done_q;
  assign err_count = errCount_q;
  assign fail      = fail_q;

endmodule

// File: tb/tb_gf_chien_search.sv
// Directed bench for gf_chien_search: known locator polynomials with
// hand-derived roots, plus mid-search start and reset protocol checks.
module tb_gf_chien_search;

  localparam int M    = 255;
  localparam int SIZE = 8;
  localparam int T    = 8;
  localparam int LW   = (T + 1) * SIZE;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [LW-1:0]   flat_lambda;
  logic            busy;
  logic            pos_valid;
  logic [SIZE-1:0] pos;
  logic            done;
  logic [SIZE-1:0] err_count;
  logic            fail;

  int checks = 0;
  int errors = 0;

  gf_chien_search #(.m(M), .SIZE(SIZE), .T(T)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .flat_lambda(flat_lambda),
    .busy       (busy),
    .pos_valid  (pos_valid),
    .pos        (pos),
    .done       (done),
    .err_count  (err_count),
    .fail       (fail)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic logic [LW-1:0] packLambda(input logic [7:0] l0, input logic [7:0] l1, input logic [7:0] l2);
    logic [LW-1:0] f;
    f = '0;
    f[7:0]   = l0;
    f[15:8]  = l1;
    f[23:16] = l2;
    return f;
  endfunction

  // Drives start for one cycle; returns just after the accepting edge.
  task automatic applyStimulus(input logic [LW-1:0] lam);
    @(negedge clk);
    flat_lambda = lam;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // One full search. Cycle c means sampled #1 after the c-th edge following
  // the accepting edge; the result for evaluation j appears at c = j+1 and
  // done at c = 255. Up to two expected roots, listed in ascending j.
  task automatic runSearch(input string tag, input logic [LW-1:0] lam,
                           input int nExp, input int expJ0, input int expJ1,
                           input int expCount, input logic expFail,
                           input int intrudeAt, input logic [LW-1:0] intrudeLam);
    int  seen;
    int  expJ;
    bit  gotDone;
    seen    = 0;
    gotDone = 0;
    applyStimulus(lam);
    checkOutput({tag, " busy after start"}, 32'(busy), 1);
    for (int c = 1; c <= 300; c++) begin
      if (c == intrudeAt) begin
        flat_lambda = intrudeLam;
        start = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (pos_valid) begin
        if (seen < nExp) begin
          expJ = (seen == 0) ? expJ0 : expJ1;
          checkOutput({tag, " pos"}, 32'(pos), 32'((M - expJ) % M));
          checkOutput({tag, " pos cycle"}, 32'(c - 1), 32'(expJ));
        end
        seen++;
      end
      if (done) begin
        gotDone = 1;
        checkOutput({tag, " done cycle"}, 32'(c), 255);
        checkOutput({tag, " err_count"}, 32'(err_count), 32'(expCount));
        checkOutput({tag, " fail"}, 32'(fail), 32'(expFail));
        checkOutput({tag, " busy at done"}, 32'(busy), 1);
        break;
      end
    end
    checkOutput({tag, " done seen"}, 32'(gotDone), 1);
    checkOutput({tag, " root events"}, 32'(seen), 32'(nExp));
    @(posedge clk);
    #1;
    checkOutput({tag, " busy after done"}, 32'(busy), 0);
    checkOutput({tag, " done one cycle"}, 32'(done), 0);
    checkOutput({tag, " pos_valid after done"}, 32'(pos_valid), 0);
    checkOutput({tag, " err_count held"}, 32'(err_count), 32'(expCount));
    checkOutput({tag, " fail held"}, 32'(fail), 32'(expFail));
  endtask

  // Directed sequence of all test steps, ending with the summary line.
  initial begin
    int donePulses;
    rst = 1'b1;
    start = 1'b0;
    flat_lambda = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busy", 32'(busy), 0);
    checkOutput("reset pos_valid", 32'(pos_valid), 0);
    checkOutput("reset done", 32'(done), 0);
    checkOutput("reset err_count", 32'(err_count), 0);
    checkOutput("reset fail", 32'(fail), 0);
    checkOutput("reset pos", 32'(pos), 0);
    rst = 1'b0;

    runSearch("t1 const", packLambda(8'h01, 8'h00, 8'h00), 0, 0, 0, 0, 1'b0, 0, '0);
    runSearch("t2 one root", packLambda(8'h01, 8'h02, 8'h00), 1, 254, 0, 1, 1'b0, 0, '0);
    runSearch("t3 two roots", packLambda(8'h01, 8'h7C, 8'h87), 2, 245, 252, 2, 1'b0, 0, '0);
    runSearch("t4 double root", packLambda(8'h01, 8'h00, 8'h01), 1, 0, 0, 1, 1'b1, 0, '0);
    runSearch("t5 lambda0 zero", packLambda(8'h00, 8'h01, 8'h00), 0, 0, 0, 0, 1'b1, 0, '0);
    runSearch("t6 start ignored", packLambda(8'h01, 8'h7C, 8'h87), 2, 245, 252, 2, 1'b0,
              50, packLambda(8'h01, 8'h02, 8'h00));

    applyStimulus(packLambda(8'h01, 8'h7C, 8'h87));
    repeat (100) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort busy", 32'(busy), 0);
    checkOutput("abort pos_valid", 32'(pos_valid), 0);
    checkOutput("abort done", 32'(done), 0);
    checkOutput("abort err_count", 32'(err_count), 0);
    rst = 1'b0;
    donePulses = 0;
    repeat (300) begin
      @(posedge clk);
      #1;
      if (done) donePulses++;
    end
    checkOutput("abort no done", 32'(donePulses), 0);

    runSearch("t7 after abort", packLambda(8'h01, 8'h02, 8'h00), 1, 254, 0, 1, 1'b0, 0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
